// File: rtl/unit_addr_responder.sv
// Device-side responder for the unit operation bus: two-stage pipeline executing
// reads/writes against a 16x8 register file and a read-only completion counter.
module unit_addr_responder (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable_in,
  input  logic       wr_rd_op,
  input  logic       valid_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] op_in_id,
  input  logic [7:0] wr_data_in,
  output logic       ready_out,
  output logic [7:0] rd_data_out,
  output logic [7:0] done_op_id
);

  localparam logic [7:0] CNT_ADDR      = 8'hFE;
  localparam logic [7:0] UNMAPPED_DATA = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       ready_q, ready_d;

  logic       s1_valid_q, s1_wr_q;
  logic [7:0] s1_addr_q, s1_id_q, s1_data_q;
  logic       s2_valid_q, s2_wr_q;
  logic [7:0] s2_addr_q, s2_id_q, s2_data_q;

  logic [7:0] regs_q [16];
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] done_q, done_d;
  logic [7:0] rd_q, rd_d;

  logic       accept_s;
  logic       pipe_busy_s;
  logic       wr_en_s;
  logic [7:0] rd_val_s;

  function automatic logic is_reg_addr(input logic [7:0] addr);
    return (addr[7:4] == 4'h0);
  endfunction

  assign accept_s    = enable_in & valid_in & ready_q;
  assign pipe_busy_s = s1_valid_q | s2_valid_q;
  assign ready_out   = ready_q;
  assign rd_data_out = rd_q;
  assign done_op_id  = done_q;

  // Next-state logic for the enable/drain controller
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_in) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!enable_in) begin
          state_d = pipe_busy_s ? ST_DRAIN : ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy_s) begin
          state_d = enable_in ? ST_ACTIVE : ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_ACTIVE);
  end

  // Execute stage: address decode, completion outputs and counter update
  always_comb begin
    rd_val_s = UNMAPPED_DATA;
    done_d   = 8'h00;
    rd_d     = 8'h00;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    if (is_reg_addr(s2_addr_q)) begin
      rd_val_s = regs_q[s2_addr_q[3:0]];
    end else if (s2_addr_q == CNT_ADDR) begin
      rd_val_s = cnt_q;
    end else begin
      rd_val_s = UNMAPPED_DATA;
    end
    if (s2_valid_q) begin
      done_d  = s2_id_q;
      rd_d    = s2_wr_q ? 8'h00 : rd_val_s;
      cnt_d   = cnt_q + 8'd1;
      wr_en_s = s2_wr_q & is_reg_addr(s2_addr_q);
    end else begin
      done_d  = 8'h00;
      rd_d    = 8'h00;
      cnt_d   = cnt_q;
      wr_en_s = 1'b0;
    end
  end

  // Controller state and registered ready
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Pipeline stages; reset flushes in-flight ops without reporting them
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_addr_q  <= 8'h00;
      s1_id_q    <= 8'h00;
      s1_data_q  <= 8'h00;
      s2_valid_q <= 1'b0;
      s2_wr_q    <= 1'b0;
      s2_addr_q  <= 8'h00;
      s2_id_q    <= 8'h00;
      s2_data_q  <= 8'h00;
    end else begin
      s1_valid_q <= accept_s;
      s1_wr_q    <= wr_rd_op;
      s1_addr_q  <= addr_in;
      s1_id_q    <= op_in_id;
      s1_data_q  <= wr_data_in;
      s2_valid_q <= s1_valid_q;
      s2_wr_q    <= s1_wr_q;
      s2_addr_q  <= s1_addr_q;
      s2_id_q    <= s1_id_q;
      s2_data_q  <= s1_data_q;
    end
  end

  // Register file, completion counter and completion outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
      cnt_q  <= 8'h00;
      done_q <= 8'h00;
      rd_q   <= 8'h00;
    end else begin
      if (wr_en_s) begin
        regs_q[s2_addr_q[3:0]] <= s2_data_q;
      end
      cnt_q  <= cnt_d;
      done_q <= done_d;
      rd_q   <= rd_d;
    end
  end

endmodule

// File: tb/tb_unit_addr_responder.sv
// Randomized scoreboard bench for unit_addr_responder; the reference model
// predicts each completion at acceptance time from the address-map rules.
module tb_unit_addr_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable_in, wr_rd_op, valid_in;
  logic [7:0] addr_in, op_in_id, wr_data_in;
  logic       ready_out;
  logic [7:0] rd_data_out, done_op_id;

  unit_addr_responder dut (
    .clock      (clock),
    .reset      (reset),
    .enable_in  (enable_in),
    .wr_rd_op   (wr_rd_op),
    .valid_in   (valid_in),
    .addr_in    (addr_in),
    .op_in_id   (op_in_id),
    .wr_data_in (wr_data_in),
    .ready_out  (ready_out),
    .rd_data_out(rd_data_out),
    .done_op_id (done_op_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] id;
    logic [7:0] rd;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem [16];
  logic [7:0] m_cnt   = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_drain = 1'b0;
  int         cyc     = 0;
  int         checks  = 0;
  int         errors  = 0;

  // Reference model: predicts acceptance, completion data and ready at every edge
  always @(posedge clock) begin
    bit   busy;
    exp_t e;
    cyc = cyc + 1;
    if (reset !== 1'b1) begin
      sb_q.delete();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      m_cnt   = 8'h00;
      m_ready = 1'b0;
      m_drain = 1'b0;
    end else begin
      busy = (sb_q.size() != 0);
      if (enable_in && valid_in && m_ready) begin
        e.id  = op_in_id;
        e.due = cyc + 2;
        if (wr_rd_op) begin
          if (addr_in < 8'h10) mem[addr_in[3:0]] = wr_data_in;
          e.rd = 8'h00;
        end else if (addr_in < 8'h10) begin
          e.rd = mem[addr_in[3:0]];
        end else if (addr_in == 8'hFE) begin
          e.rd = m_cnt;
        end else begin
          e.rd = 8'hEE;
        end
        m_cnt = m_cnt + 8'd1;
        sb_q.push_back(e);
      end
      if (m_ready) begin
        m_drain = !enable_in && busy;
        m_ready = enable_in;
      end else if (m_drain) begin
        if (!busy) begin
          m_drain = 1'b0;
          m_ready = enable_in;
        end
      end else begin
        m_ready = enable_in;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the active edge
  always @(negedge clock) begin
    exp_t e;
    checks++;
    if (ready_out !== m_ready) begin
      errors++;
      $display("FAIL ready cyc=%0d actual=%b expected=%b", cyc, ready_out, m_ready);
    end
    if (done_op_id !== 8'h00) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d actual id=%h rd=%h expected none", cyc, done_op_id, rd_data_out);
      end else begin
        e = sb_q.pop_front();
        if (done_op_id !== e.id || rd_data_out !== e.rd || cyc != e.due) begin
          errors++;
          $display("FAIL completion cyc=%0d actual id=%h rd=%h expected id=%h rd=%h at cyc=%0d",
                   cyc, done_op_id, rd_data_out, e.id, e.rd, e.due);
        end
      end
    end else begin
      checks++;
      if (rd_data_out !== 8'h00) begin
        errors++;
        $display("FAIL idle_rd cyc=%0d actual=%h expected=00", cyc, rd_data_out);
      end
      if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        checks++;
        errors++;
        e = sb_q.pop_front();
        $display("FAIL missing_done cyc=%0d actual id=00 expected id=%h rd=%h", cyc, e.id, e.rd);
      end
    end
  end

  task automatic drive(input logic rst, input logic en, input logic v, input logic wr,
                       input logic [7:0] a, input logic [7:0] id, input logic [7:0] d);
    @(negedge clock);
    reset      = rst;
    enable_in  = en;
    valid_in   = v;
    wr_rd_op   = wr;
    addr_in    = a;
    op_in_id   = id;
    wr_data_in = d;
  endtask

  task automatic idle(input logic rst, input logic en, input int n);
    for (int i = 0; i < n; i++) drive(rst, en, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 1'b0; enable_in = 1'b0; valid_in = 1'b0; wr_rd_op = 1'b0;
    addr_in = 8'h00; op_in_id = 8'h00; wr_data_in = 8'h00;

    // Reset with enable held high, then ready rises one cycle after release
    idle(1'b0, 1'b1, 3);
    idle(1'b1, 1'b1, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'h11, 8'h5A);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 8'h12, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h40, 8'h21, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 8'h22, 8'h77);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h23, 8'h00);
    idle(1'b1, 1'b1, 3);

    // Counter wrap after 256 completions
    idle(1'b0, 1'b0, 2);
    idle(1'b1, 1'b1, 1);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
            8'($urandom_range(1, 255)), 8'($urandom));
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h55, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h56, 8'h00);

    // Drain: two ops in flight, enable drops, valid pulse while draining
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 8'h31, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h06, 8'h32, 8'h00);
    idle(1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h07, 8'h33, 8'h00);
    idle(1'b1, 1'b0, 3);
    idle(1'b1, 1'b1, 2);

    // Reset right after acceptance flushes the op and the register file
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 8'h41, 8'h99);
    idle(1'b0, 1'b1, 1);
    idle(1'b1, 1'b1, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 8'h42, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 8'h43, 8'h00);
    idle(1'b1, 1'b1, 3);

    // Randomized traffic with occasional enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      int         sel;
      sel = $urandom_range(0, 7);
      if (sel < 5)       a = 8'($urandom_range(0, 15));
      else if (sel == 5) a = 8'hFE;
      else               a = 8'($urandom);
      drive(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 15) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
            8'($urandom_range(1, 255)), 8'($urandom));
    end
    idle(1'b1, 1'b1, 6);

    @(posedge clock);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover actual=%0d outstanding expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
